pixel_packer: RTL and testbench

Packs the 8-bit pixel stream from the camera capture stage into 32-bit words for the USB3 transmit path, and flags the last word of each frame. Sits directly downstream of capture in the camera pixel-clock domain. A small first-word-fall-through FIFO absorbs downstream stalls, and a registered `out_ready` throttles the capture stage.

---
 rtl/usb_cam_pkg.sv | 20 ++
 rtl/sync_fifo_fwft.sv | 66 ++++++
 rtl/pixel_packer.sv | 126 ++++++++++++
 tb/tb_pixel_packer.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/usb_cam_pkg.sv
// ============================================================================
// Module : usb_cam_pkg
// Desc   : Constants and helpers shared by the camera capture/USB3 transmit path
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package usb_cam_pkg;

    localparam int WORD_W         = 32;
    localparam int BYTES_PER_WORD = 4;

    // Both the packer and the transmit controller size frames with this.
    function automatic int frame_bytes(input int im_x, input int im_y, input int color_mode);
        return im_x * im_y * color_mode;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sync_fifo_fwft.sv
// ============================================================================
// Module : sync_fifo_fwft
// Desc   : Single-clock first-word-fall-through FIFO with synchronous flush
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_fifo_fwft #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   wr_en,
    input  logic [WIDTH-1:0]       wr_data,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count,
    input  logic                   rd_en,
    output logic [WIDTH-1:0]       rd_data,
    output logic                   empty
);

    localparam int                c_ADDR_W  = $clog2(DEPTH);
    localparam logic [c_ADDR_W:0] c_PTR_ONE = (c_ADDR_W + 1)'(1);

    logic [WIDTH-1:0]  r_mem [DEPTH];
    logic [c_ADDR_W:0] r_wr_ptr;
    logic [c_ADDR_W:0] r_rd_ptr;
    logic              w_do_rd;
    logic              w_do_wr;

    assign empty   = (r_wr_ptr == r_rd_ptr);
    assign full    = (r_wr_ptr[c_ADDR_W] != r_rd_ptr[c_ADDR_W]) &&
                     (r_wr_ptr[c_ADDR_W-1:0] == r_rd_ptr[c_ADDR_W-1:0]);
    assign count   = r_wr_ptr - r_rd_ptr;
    assign rd_data = r_mem[r_rd_ptr[c_ADDR_W-1:0]];

    // A pop frees a slot in the same cycle, so a write into a full FIFO is
    // still accepted when the head is being consumed.
    assign w_do_rd = rd_en && !empty;
    assign w_do_wr = wr_en && (!full || w_do_rd);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (flush) begin
            r_rd_ptr <= r_wr_ptr;
        end else begin
            if (w_do_wr) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            if (w_do_rd) r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (w_do_wr && !flush) begin
            r_mem[r_wr_ptr[c_ADDR_W-1:0]] <= wr_data;
        end
    end

endmodule

`default_nettype wire

// File: rtl/pixel_packer.sv
// ============================================================================
// Module : pixel_packer
// Desc   : Packs 8-bit capture bytes into 32-bit words with end-of-frame flag
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pixel_packer
    import usb_cam_pkg::*;
#(
    parameter int COLOR_MODE = 1,
    parameter int IM_X       = 1280,
    parameter int IM_Y       = 720,
    parameter int FIFO_DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_stream,
    input  logic [7:0]        pixel,
    input  logic              pixel_valid,
    output logic              out_ready,
    output logic [WORD_W-1:0] word_data,
    output logic              word_last,
    output logic              word_valid,
    input  logic              word_ready,
    output logic              overflow
);

    localparam int c_FRAME_BYTES = frame_bytes(IM_X, IM_Y, COLOR_MODE);
    localparam int c_CNT_W       = $clog2(c_FRAME_BYTES);
    localparam int c_LANE_W      = $clog2(BYTES_PER_WORD);
    localparam int c_FIFO_CW     = $clog2(FIFO_DEPTH) + 1;

    localparam logic [c_CNT_W-1:0]   c_LAST_BYTE   = c_CNT_W'(c_FRAME_BYTES - 1);
    localparam logic [c_CNT_W-1:0]   c_CNT_ONE     = c_CNT_W'(1);
    localparam logic [c_LANE_W-1:0]  c_TOP_LANE    = c_LANE_W'(BYTES_PER_WORD - 1);
    localparam logic [c_LANE_W-1:0]  c_LANE_ONE    = c_LANE_W'(1);
    localparam logic [c_FIFO_CW-1:0] c_READY_LIMIT = c_FIFO_CW'(FIFO_DEPTH - 3);

    logic [c_LANE_W-1:0]  r_lane;
    logic [c_CNT_W-1:0]   r_byte_cnt;
    logic [WORD_W-1:0]    r_partial;
    logic                 r_push;
    logic [WORD_W-1:0]    r_push_word;
    logic                 r_push_last;
    logic                 r_out_ready;
    logic                 r_overflow;

    logic                 w_accept;
    logic                 w_frame_end;
    logic                 w_group_done;
    logic [WORD_W-1:0]    w_word;
    logic                 w_fifo_full;
    logic                 w_fifo_empty;
    logic [c_FIFO_CW-1:0] w_fifo_count;
    logic [WORD_W:0]      w_head;

    assign w_accept     = start_stream && pixel_valid;
    assign w_frame_end  = (r_byte_cnt == c_LAST_BYTE);
    assign w_group_done = (r_lane == c_TOP_LANE) || w_frame_end;
    // Lanes above the current one are still zero because the partial word is
    // cleared on every push and on abort.
    assign w_word       = r_partial | (WORD_W'(pixel) << {r_lane, 3'b000});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lane      <= '0;
            r_byte_cnt  <= '0;
            r_partial   <= '0;
            r_push      <= 1'b0;
            r_push_word <= '0;
            r_push_last <= 1'b0;
        end else if (!start_stream) begin
            r_lane     <= '0;
            r_byte_cnt <= '0;
            r_partial  <= '0;
            r_push     <= 1'b0;
        end else begin
            r_push <= w_accept && w_group_done;
            if (w_accept) begin
                r_push_word <= w_word;
                r_push_last <= w_frame_end;
                r_partial   <= w_group_done ? '0 : w_word;
                r_lane      <= w_frame_end ? '0 : (r_lane + c_LANE_ONE);
                r_byte_cnt  <= w_frame_end ? '0 : (r_byte_cnt + c_CNT_ONE);
            end
        end
    end

    // A word dropped on a full FIFO still counted its bytes above, so frame
    // alignment survives an overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_ready <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_out_ready <= start_stream && (w_fifo_count <= c_READY_LIMIT);
            if (start_stream && r_push && w_fifo_full && !word_ready) r_overflow <= 1'b1;
        end
    end

    sync_fifo_fwft #(
        .WIDTH (WORD_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush   (!start_stream),
        .wr_en   (r_push),
        .wr_data ({r_push_last, r_push_word}),
        .full    (w_fifo_full),
        .count   (w_fifo_count),
        .rd_en   (word_ready),
        .rd_data (w_head),
        .empty   (w_fifo_empty)
    );

    assign out_ready  = r_out_ready;
    assign overflow   = r_overflow;
    assign word_valid = !w_fifo_empty;
    assign word_last  = w_head[WORD_W];
    assign word_data  = w_head[WORD_W-1:0];

endmodule

`default_nettype wire

// File: tb/tb_pixel_packer.sv
// ============================================================================
// Module : tb_pixel_packer
// Desc   : Directed self-checking bench for pixel_packer with word scoreboard
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pixel_packer;

    localparam int IM_X       = 3;
    localparam int IM_Y       = 2;
    localparam int COLOR_MODE = 1;
    localparam int FIFO_DEPTH = 8;
    localparam int FB         = IM_X * IM_Y * COLOR_MODE;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_stream = 1'b0;
    logic [7:0]  pixel = 8'h00;
    logic        pixel_valid = 1'b0;
    logic        word_ready = 1'b0;
    logic        out_ready;
    logic [31:0] word_data;
    logic        word_last;
    logic        word_valid;
    logic        overflow;

    int checks = 0;
    int failures = 0;

    logic [32:0] exp_q[$];
    logic [32:0] mon_exp;
    int          m_occ = 0;
    int          m_cnt = 0;
    int          m_lane = 0;
    logic [31:0] m_part = 32'h0;

    pixel_packer #(
        .COLOR_MODE (COLOR_MODE),
        .IM_X       (IM_X),
        .IM_Y       (IM_Y),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_stream (start_stream),
        .pixel        (pixel),
        .pixel_valid  (pixel_valid),
        .out_ready    (out_ready),
        .word_data    (word_data),
        .word_last    (word_last),
        .word_valid   (word_valid),
        .word_ready   (word_ready),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [32:0] obs, input logic [32:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_occ  = 0;
        m_cnt  = 0;
        m_lane = 0;
        m_part = 32'h0;
    endtask

    // Reference packing: byte k of a group lands in bits [8k+7:8k]
    task automatic send_byte(input logic [7:0] b);
        logic last;
        pixel       = b;
        pixel_valid = 1'b1;
        m_part = m_part | (32'(b) << (8 * m_lane));
        last   = (m_cnt == FB - 1);
        if (m_lane == 3 || last) begin
            if (m_occ < FIFO_DEPTH) begin
                exp_q.push_back({last, m_part});
                m_occ++;
            end
            m_part = 32'h0;
            m_lane = 0;
        end else begin
            m_lane++;
        end
        m_cnt = last ? 0 : m_cnt + 1;
        @(posedge clk);
        #1;
        pixel_valid = 1'b0;
    endtask

    task automatic send_run(input logic [7:0] first, input int n);
        for (int i = 0; i < n; i++) send_byte(first + 8'(i));
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        while ((exp_q.size() != 0 || word_valid) && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(tag, {32'd0, (exp_q.size() == 0) && !word_valid}, 33'd1);
    endtask

    always @(negedge clk) begin
        if (rst_n && word_valid && word_ready) begin
            if (exp_q.size() > 0) mon_exp = exp_q.pop_front();
            else                  mon_exp = 'x;
            if (m_occ > 0) m_occ--;
            check("word", {word_last, word_data}, mon_exp);
        end
    end

    initial begin
        // Reset values
        tick(2);
        check("rst_out_ready",  {32'd0, out_ready},  33'd0);
        check("rst_word_valid", {32'd0, word_valid}, 33'd0);
        check("rst_word_data",  {1'b0, word_data},   33'd0);
        check("rst_word_last",  {32'd0, word_last},  33'd0);
        check("rst_overflow",   {32'd0, overflow},   33'd0);
        rst_n        = 1'b1;
        start_stream = 1'b1;
        word_ready   = 1'b1;
        tick(1);
        check("out_ready_on", {32'd0, out_ready}, 33'd1);

        // Packing and one-cycle push latency
        send_run(8'h01, 4);
        check("lat_edge_n", {32'd0, word_valid}, 33'd0);
        tick(1);
        check("lat_edge_n1", {32'd0, word_valid}, 33'd1);
        check("lat_head", {word_last, word_data}, {1'b0, 32'h04030201});
        send_run(8'h05, 2);
        send_run(8'h07, 6);
        wait_drain("drain_pack");

        // Backpressure: out_ready falls one cycle after the 6th word lands
        word_ready = 1'b0;
        send_run(8'h20, 18);
        tick(1);
        check("bp_ready_n1", {32'd0, out_ready}, 33'd1);
        tick(1);
        check("bp_ready_n2", {32'd0, out_ready}, 33'd0);
        word_ready = 1'b1;
        wait_drain("drain_bp");
        check("bp_no_overflow", {32'd0, overflow}, 33'd0);
        check("bp_ready_back", {32'd0, out_ready}, 33'd1);

        // Overflow: 8 words fit, the 9th is dropped
        word_ready = 1'b0;
        send_run(8'h40, 24);
        tick(2);
        check("ovf_before", {32'd0, overflow}, 33'd0);
        check("ovf_full_ready", {32'd0, out_ready}, 33'd0);
        send_run(8'h58, 16);
        tick(2);
        check("ovf_after", {32'd0, overflow}, 33'd1);
        word_ready = 1'b1;
        wait_drain("drain_ovf");
        send_run(8'h70, 8);
        wait_drain("drain_align");
        check("ovf_sticky", {32'd0, overflow}, 33'd1);

        // Abort with one word queued and a partial word in the packer
        word_ready = 1'b0;
        send_run(8'h30, 5);
        tick(2);
        check("abort_pre_valid", {32'd0, word_valid}, 33'd1);
        start_stream = 1'b0;
        pixel        = 8'hEE;
        pixel_valid  = 1'b1;
        model_reset();
        tick(1);
        check("abort_valid", {32'd0, word_valid}, 33'd0);
        check("abort_ready", {32'd0, out_ready}, 33'd0);
        pixel_valid  = 1'b0;
        start_stream = 1'b1;
        word_ready   = 1'b1;
        tick(1);
        send_run(8'h10, 6);
        wait_drain("drain_abort");

        // Asynchronous reset in the middle of a frame
        send_run(8'h50, 2);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_out_ready",  {32'd0, out_ready},  33'd0);
        check("arst_word_valid", {32'd0, word_valid}, 33'd0);
        check("arst_word_data",  {1'b0, word_data},   33'd0);
        check("arst_word_last",  {32'd0, word_last},  33'd0);
        check("arst_overflow",   {32'd0, overflow},   33'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("arst_empty", {32'd0, word_valid}, 33'd0);
        tick(1);
        check("arst_ready_back", {32'd0, out_ready}, 33'd1);
        send_run(8'h60, 6);
        wait_drain("drain_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
